secure_reg_arbiter: RTL and testbench

SECURE_REG_ARBITER -- requirements
Module: secure_reg_arbiter

---
 rtl/secure_reg_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_secure_reg_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secure_reg_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters fixed-latency access to one secure register.
// Optional per-requester violation lockout is compiled in when SECURE_ARB_LOCKOUT_EN is defined.
module secure_reg_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REQ     = 4,
  parameter int TID_WIDTH   = 4,
  parameter int LOCK_THRESH = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*TID_WIDTH-1:0]    req_tid,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_rdata,
  output logic                            resp_err,
  output logic                            reg_access_en,
  output logic                            reg_wr_en,
  output logic [DATA_WIDTH-1:0]           reg_data_in,
  output logic [TID_WIDTH-1:0]            reg_thread_id,
  input  logic [DATA_WIDTH-1:0]           reg_data_out,
  output logic [NUM_REQ-1:0]              lock_status
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   wr_q, wr_d;
  logic                   perm_q, perm_d;
  logic [IDX_W-1:0]       sel_s;
  logic                   sel_found_s;
  logic [NUM_REQ-1:0]     eligible_s;
  logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]  resp_rdata_q, resp_rdata_d;
  logic                   resp_err_q, resp_err_d;
  logic                   reg_access_en_q, reg_access_en_d;
  logic                   reg_wr_en_q, reg_wr_en_d;
  logic [DATA_WIDTH-1:0]  reg_data_in_q, reg_data_in_d;
  logic [TID_WIDTH-1:0]   reg_thread_id_q, reg_thread_id_d;

  if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_THRESH < 1 || LOCK_THRESH > 7) begin : g_param_check
    $error("secure_reg_arbiter: parameter out of range");
  end

`ifdef SECURE_ARB_LOCKOUT_EN
  logic [NUM_REQ-1:0][2:0] viol_q, viol_d;
  logic [NUM_REQ-1:0]      lock_q, lock_d;

  // Saturating violation count per requester; lock is sticky once the threshold is met.
  always_comb begin
    viol_d = viol_q;
    lock_d = lock_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q == RESP && !perm_q && idx_q == IDX_W'(i) && viol_q[i] != 3'd7) begin
        viol_d[i] = viol_q[i] + 3'd1;
      end else begin
        viol_d[i] = viol_q[i];
      end
      if (viol_d[i] >= 3'(LOCK_THRESH)) begin
        lock_d[i] = 1'b1;
      end else begin
        lock_d[i] = lock_q[i];
      end
    end
  end

  // Violation counter and lock registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_q <= '0;
      lock_q <= '0;
    end else begin
      viol_q <= viol_d;
      lock_q <= lock_d;
    end
  end

  assign eligible_s  = req & ~lock_q;
  assign lock_status = lock_q;
`else
  assign eligible_s  = req;
  assign lock_status = '0;
`endif

  // First eligible requester at or after the round-robin pointer.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand        = '0;
    sel_found_s = 1'b0;
    sel_s       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!sel_found_s && eligible_s[cand]) begin
        sel_found_s = 1'b1;
        sel_s       = cand;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Next-state and next-output logic; every path takes the same four cycles.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    idx_d           = idx_q;
    wr_d            = wr_q;
    perm_d          = perm_q;
    resp_valid_d    = '0;
    resp_rdata_d    = '0;
    resp_err_d      = 1'b0;
    reg_access_en_d = 1'b0;
    reg_wr_en_d     = 1'b0;
    reg_data_in_d   = '0;
    reg_thread_id_d = '0;
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          idx_d           = sel_s;
          wr_d            = req_wr[sel_s];
          perm_d          = (req_tid[int'(sel_s)*TID_WIDTH +: TID_WIDTH] == '0);
          reg_access_en_d = perm_d;
          reg_wr_en_d     = perm_d & wr_d;
          if (perm_d) begin
            reg_data_in_d   = req_wdata[int'(sel_s)*DATA_WIDTH +: DATA_WIDTH];
            reg_thread_id_d = req_tid[int'(sel_s)*TID_WIDTH +: TID_WIDTH];
          end else begin
            reg_data_in_d   = '0;
            reg_thread_id_d = '0;
          end
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        resp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
        resp_err_d   = !perm_q;
        if (perm_q && !wr_q) begin
          resp_rdata_d = reg_data_out;
        end else begin
          resp_rdata_d = '0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (idx_q == IDX_W'(NUM_REQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = idx_q + IDX_W'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, transaction context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      idx_q           <= '0;
      wr_q            <= 1'b0;
      perm_q          <= 1'b0;
      resp_valid_q    <= '0;
      resp_rdata_q    <= '0;
      resp_err_q      <= 1'b0;
      reg_access_en_q <= 1'b0;
      reg_wr_en_q     <= 1'b0;
      reg_data_in_q   <= '0;
      reg_thread_id_q <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      idx_q           <= idx_d;
      wr_q            <= wr_d;
      perm_q          <= perm_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
      reg_access_en_q <= reg_access_en_d;
      reg_wr_en_q     <= reg_wr_en_d;
      reg_data_in_q   <= reg_data_in_d;
      reg_thread_id_q <= reg_thread_id_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign reg_access_en = reg_access_en_q;
  assign reg_wr_en     = reg_wr_en_q;
  assign reg_data_in   = reg_data_in_q;
  assign reg_thread_id = reg_thread_id_q;

endmodule

// File: tb/tb_secure_reg_arbiter.sv
// Scoreboard bench for secure_reg_arbiter: a transaction-level model predicts issue strobes and
// responses, and a negedge monitor compares them against the DUT.
module tb_secure_reg_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int LT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_v = '0;
  logic [NR-1:0]     wr_v = '0;
  logic [NR*DW-1:0]  wdata_v = '0;
  logic [NR*TW-1:0]  tid_v = '0;
  logic [NR-1:0]     resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic              resp_err;
  logic              reg_access_en;
  logic              reg_wr_en;
  logic [DW-1:0]     reg_data_in;
  logic [TW-1:0]     reg_thread_id;
  logic [DW-1:0]     reg_data_out = '0;
  logic [NR-1:0]     lock_status;

  int total = 0;
  int bad = 0;

  secure_reg_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TID_WIDTH(TW), .LOCK_THRESH(LT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req_v), .req_wr(wr_v), .req_wdata(wdata_v), .req_tid(tid_v),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .reg_access_en(reg_access_en), .reg_wr_en(reg_wr_en), .reg_data_in(reg_data_in),
    .reg_thread_id(reg_thread_id), .reg_data_out(reg_data_out), .lock_status(lock_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // The secure register: latency-one read, garbage on its output when not accessed.
  logic [DW-1:0] reg_mem = 32'h1234_5678;
  always @(posedge clk) begin
    if (reg_access_en) begin
      if (reg_wr_en) reg_mem <= reg_data_in;
      reg_data_out <= reg_mem;
    end else begin
      reg_data_out <= $urandom;
    end
  end

  typedef struct { int cyc; logic acc; logic wr; logic [DW-1:0] din; } iss_t;
  typedef struct { int cyc; int idx; logic err; logic [DW-1:0] rdata; } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  int            cyc = 0;
  int            m_rr = 0;
  int            m_free_at = 0;
  int            m_win;
  bit            m_found;
  logic [DW-1:0] m_mem = 32'h1234_5678;
  logic [DW-1:0] m_mem_before;
  bit            m_wr_pending = 1'b0;
  int            m_wr_commit;
  logic [NR-1:0] mlock = '0;
  int            mviol [NR];

  // Transaction model: one access at a time, round-robin, permitted only for thread 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (m_wr_pending && cyc < m_wr_commit) m_mem = m_mem_before;
      m_wr_pending = 1'b0;
      iss_q.delete();
      rsp_q.delete();
      m_rr = 0;
      m_free_at = 0;
      mlock = '0;
      for (int i = 0; i < NR; i++) mviol[i] = 0;
    end else begin
      cyc++;
      if (cyc >= m_free_at) begin
        m_found = 1'b0;
        m_win = 0;
        for (int k = 0; k < NR; k++) begin
          if (!m_found && req_v[(m_rr + k) % NR] && !mlock[(m_rr + k) % NR]) begin
            m_found = 1'b1;
            m_win = (m_rr + k) % NR;
          end
        end
        if (m_found) begin
          iss_t ie;
          rsp_t re;
          logic perm;
          logic w;
          logic [DW-1:0] d;
          perm = (tid_v[m_win*TW +: TW] == 4'd0);
          w = wr_v[m_win];
          d = wdata_v[m_win*DW +: DW];
          ie.cyc = cyc;
          ie.acc = perm;
          ie.wr = perm & w;
          ie.din = perm ? d : 32'd0;
          iss_q.push_back(ie);
          re.cyc = cyc + 2;
          re.idx = m_win;
          re.err = !perm;
          re.rdata = (perm && !w) ? m_mem : 32'd0;
          rsp_q.push_back(re);
          if (perm && w) begin
            m_mem_before = m_mem;
            m_mem = d;
            m_wr_pending = 1'b1;
            m_wr_commit = cyc + 1;
          end
`ifdef SECURE_ARB_LOCKOUT_EN
          if (!perm) begin
            if (mviol[m_win] < 7) mviol[m_win]++;
            if (mviol[m_win] >= LT) mlock[m_win] = 1'b1;
          end
`endif
          m_rr = (m_win + 1) % NR;
          m_free_at = cyc + 4;
        end
      end
    end
  end

  // Monitor: pops expected issue/response entries when due, otherwise expects quiet outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        iss_t ie;
        ie = iss_q.pop_front();
        chk("issue", {reg_access_en, reg_wr_en, reg_data_in}, {ie.acc, ie.wr, ie.din});
        if (ie.acc) chk("issue_tid", reg_thread_id, 64'd0);
      end else begin
        chk("issue_idle", {reg_access_en, reg_wr_en}, 64'd0);
      end
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
        rsp_t re;
        re = rsp_q.pop_front();
        chk("resp_valid", resp_valid, 64'd1 << re.idx);
        chk("resp_rdata", resp_rdata, re.rdata);
        chk("resp_err", resp_err, re.err);
      end else begin
        chk("resp_quiet", {resp_valid, resp_err, resp_rdata}, 64'd0);
      end
    end
  end

  task automatic set_req(input int i, input logic w, input logic [DW-1:0] d, input logic [TW-1:0] t);
    wr_v[i] = w;
    wdata_v[i*DW +: DW] = d;
    tid_v[i*TW +: TW] = t;
    req_v[i] = 1'b1;
  endtask

  task automatic do_single(input int i, input logic w, input logic [DW-1:0] d, input logic [TW-1:0] t);
    bit got;
    got = 1'b0;
    @(negedge clk);
    set_req(i, w, d, t);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (resp_valid[i]) got = 1'b1;
    end
    req_v[i] = 1'b0;
    chk("single_done", got, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_v = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int order [5];
  int when [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};
  int npulse;
  bit saw0, saw2, seen_acc;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_resp", {resp_valid, resp_err, resp_rdata}, 64'd0);
    chk("rst_reg", {reg_access_en, reg_wr_en, reg_thread_id, reg_data_in}, 64'd0);
    chk("rst_lock", lock_status, 64'd0);
    rst_n = 1'b1;

    // Round robin with all requesters holding.
    @(negedge clk);
    for (int i = 0; i < NR; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom, 4'd0);
    npulse = 0;
    for (int n = 0; n < 40 && npulse < 5; n++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        for (int i = 0; i < NR; i++) if (resp_valid[i]) order[npulse] = i;
        when[npulse] = cyc;
        npulse++;
      end
    end
    req_v = '0;
    chk("rr_count", npulse, 64'd5);
    for (int n = 0; n < 5 && n < npulse; n++) chk("rr_order", order[n], exp_order[n]);
    for (int n = 1; n < 5 && n < npulse; n++) chk("rr_period", when[n] - when[n-1], 64'd4);

    do_single(0, 1'b1, 32'hDEAD_BEEF, 4'd0);
    do_single(1, 1'b0, $urandom, 4'd5);
    do_single(3, 1'b0, 32'd0, 4'd0);

    // Randomized traffic; requesters hold req until their response.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req_v[i] && (resp_valid[i] || mlock[i])) req_v[i] = 1'b0;
        else if (!req_v[i] && !mlock[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
      end
    end
    for (int c = 0; c < 100 && req_v != '0; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) if (req_v[i] && (resp_valid[i] || mlock[i])) req_v[i] = 1'b0;
    end
    chk("drain", req_v, 64'd0);
    repeat (4) @(negedge clk);
    chk("lock_vs_model", lock_status, mlock);

    // Reset in the middle of a permitted write.
    @(negedge clk);
    set_req(0, 1'b1, 32'hA5A5_0F0F, 4'd0);
    seen_acc = 1'b0;
    for (int n = 0; n < 10 && !seen_acc; n++) begin
      @(negedge clk);
      if (reg_access_en) seen_acc = 1'b1;
    end
    chk("abort_saw_issue", seen_acc, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_acc_async", {reg_access_en, reg_wr_en}, 64'd0);
    chk("abort_resp", resp_valid, 64'd0);
    req_v = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_single(0, 1'b0, 32'd0, 4'd0);

    // Three denials from requester 2, then it must be ignored while requester 0 is served.
    do_reset();
    for (int n = 0; n < 3; n++) do_single(2, 1'b0, 32'd0, 4'd7);
    repeat (2) @(negedge clk);
`ifdef SECURE_ARB_LOCKOUT_EN
    chk("lock_after_3", lock_status, 64'h4);
`else
    chk("lock_after_3", lock_status, 64'h0);
`endif
    @(negedge clk);
    set_req(2, 1'b0, 32'd0, 4'd0);
    set_req(0, 1'b0, 32'd0, 4'd0);
    saw0 = 1'b0;
    saw2 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (resp_valid[0]) begin saw0 = 1'b1; req_v[0] = 1'b0; end
      if (resp_valid[2]) begin saw2 = 1'b1; req_v[2] = 1'b0; end
    end
    req_v = '0;
    chk("req0_served", saw0, 64'd1);
`ifdef SECURE_ARB_LOCKOUT_EN
    chk("req2_locked_out", saw2, 64'd0);
`else
    chk("req2_locked_out", saw2, 64'd1);
`endif
    repeat (4) @(negedge clk);
    chk("lock_final", lock_status, mlock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
